// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling FSM and a
// first-word fall-through receive FIFO with sticky frame/overrun flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [15:0]           baud_div_i,
  input  logic                  rx_en_i,
  input  logic                  rx_i,
  input  logic                  rx_re_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic                  rx_p0;
  logic                  rx_p1;
  logic                  rx_s;
  logic [1:0]            state;
  logic [15:0]           cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [15:0]           half_last;
  logic [15:0]           bit_last;
  logic                  half_hit;
  logic                  bit_hit;
  logic                  stop_done;
  logic                  push_req;
  logic                  pop;
  logic                  push;
  logic                  ovr_set;
  logic                  ferr_set;

  // Stage p0/p1: line synchronizer, reset to idle-high so reset never looks like a start bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  assign half_last = (baud_div_i >> 1) - 16'd1;
  assign bit_last  = baud_div_i - 16'd1;
  assign half_hit  = (cnt == half_last);
  assign bit_hit   = (cnt == bit_last);

  assign stop_done = (state == STOP) && bit_hit;
  assign push_req  = stop_done && rx_s;
  assign pop       = rx_re_i && !empty_o;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the frame
  assign push      = push_req && (!full_o || pop);
  assign ovr_set   = push_req && full_o && !pop;
  assign ferr_set  = stop_done && !rx_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_en_i && !rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (half_hit) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_hit) begin
            cnt     <= '0;
            // LSB arrives first and ends up in bit 0 after DATA_WIDTH shifts
            shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_hit) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= shift;
    end
  end

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

  // Set wins over clear when both land on the same edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (ferr_set) begin
        frame_err_o <= 1'b1;
      end else if (err_clr_i) begin
        frame_err_o <= 1'b0;
      end
      if (ovr_set) begin
        overrun_o <= 1'b1;
      end else if (err_clr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame and the FIFO word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the number of receive FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 clk_i  input  1  system clock; all logic on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 baud_div_i  input  16  clock cycles per bit period; the valid range is 4..65535.
REQ-006 rx_en_i  input  1  receiver enable; a start bit is detected only while this is high.
REQ-007 rx_i  input  1  serial line, asynchronous to clk_i, idle high.
REQ-008 rx_re_i  input  1  FIFO read strobe; pops the head entry when empty_o=0.
REQ-009 err_clr_i  input  1  clears the sticky error flags.
REQ-010 dout_o  output  DATA_WIDTH  FIFO head data, first-word fall-through; valid when empty_o=0.
REQ-011 empty_o  output  1  FIFO holds 0 entries.
REQ-012 full_o  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 frame_err_o  output  1  sticky flag: a frame was received with stop bit = 0.
REQ-014 overrun_o  output  1  sticky flag: a valid frame was dropped because the FIFO was full.
REQ-015 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 rx_i SHALL pass through a 2-flop synchronizer before any use; all references below to the line mean the synchronized value rx_s.
REQ-017 The FSM SHALL have states IDLE, START, DATA and STOP, and a 16-bit baud counter cnt that is held at 0 in IDLE.
REQ-018 IDLE: when rx_en_i=1 and rx_s=0, the FSM SHALL go to START with cnt=0; when rx_en_i=0, it SHALL remain in IDLE.
REQ-019 START: at cnt==(baud_div_i>>1)-1 (mid start bit), rx_s=0 SHALL go to DATA with cnt=0 and bit_cnt=0; rx_s=1 (false start) SHALL go to IDLE and push nothing.
REQ-020 DATA: at cnt==baud_div_i-1, the FSM SHALL sample rx_s into shift[bit_cnt] (LSB first), reset cnt to 0, and increment bit_cnt; after bit DATA_WIDTH-1 it SHALL go to STOP.
REQ-021 STOP: at cnt==baud_div_i-1, the FSM SHALL sample rx_s and go to IDLE; a following start edge is accepted from the next cycle.
REQ-022 STOP sample=1 with FIFO not full SHALL push shift into the FIFO in that same cycle.
REQ-023 STOP sample=1 with FIFO full SHALL drop the byte, leave the FIFO unchanged, and set overrun_o.
REQ-024 STOP sample=0 SHALL drop the byte and set frame_err_o.
REQ-025 A push with the FIFO full and rx_re_i=1 in the same cycle SHALL perform both the pop and the push; no overrun is flagged.
REQ-026 A pop and a push in the same cycle with the FIFO non-empty SHALL leave the occupancy unchanged.
REQ-027 rx_re_i with empty_o=1 SHALL be ignored: no pointer change, no error.
REQ-028 When empty_o=0, dout_o SHALL equal the oldest entry combinationally; it SHALL update in the cycle after a pop.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full_o and empty_o SHALL derive from an extra pointer MSB or an occupancy count.
REQ-030 err_clr_i SHALL clear both sticky flags on the next edge; a set event in the same cycle SHALL win over the clear.
REQ-031 Deasserting rx_en_i mid-frame SHALL NOT abort the frame; only new start detection is gated.
REQ-032 A change to baud_div_i mid-frame SHALL take effect on the next compare; correct data under such a change is not guaranteed.

Reset
REQ-033 On rst_ni=0, the block SHALL immediately set the state to IDLE, clear cnt, bit_cnt and shift to 0, clear both FIFO pointers, and set empty_o=1, full_o=0, frame_err_o=0, overrun_o=0, busy_o=0, dout_o=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a fresh falling edge on rx_s.
REQ-035 The synchronizer flops SHALL reset to 1 so that no spurious start bit is detected after reset.

Verification
REQ-036 baud_div=16, rx_en=1, send frame 0xA5 with stop=1 -> empty_o falls about 160 cycles after the start edge, dout_o=0xA5, no error flags.
REQ-037 Low glitch of 4 cycles on rx_i, baud_div=16 -> busy_o pulses, the FSM returns to IDLE, no push, empty_o stays 1.
REQ-038 Send 0x3C with stop bit=0 -> frame_err_o=1, FIFO stays empty; pulse err_clr_i -> frame_err_o=0.
REQ-039 FIFO_DEPTH=16, send 17 frames 0x00..0x10 without reading -> full_o=1, overrun_o=1, reads return 0x00..0x0F in order, then empty_o=1.
REQ-040 FIFO full, rx_re_i=1 in the cycle of the 17th stop sample -> no overrun, full_o stays 1, 0x10 becomes the last entry.
REQ-041 Assert rst_ni=0 during bit 3 of a frame, then release and send 0x5A -> only 0x5A is received, all flags at their reset values.
